// File: rtl/hammer_hit_detector_if.sv
// Signal bundle between the hit detector, the mole controller and the hammer debouncer.
interface hammer_hit_detector_if #(
  parameter int LANES  = 5,
  parameter int MISS_W = 8
);
  logic              enable;
  logic              clear_miss;
  logic [LANES-1:0]  mole_led;
  logic [LANES-1:0]  swith;
  logic              hammer_pulse;
  logic [LANES-1:0]  hit_vec;
  logic              miss_pulse;
  logic [MISS_W-1:0] miss_count;
  logic [LANES-1:0]  primed_vec;
  logic              lockout_busy;

  modport master (
    output enable, clear_miss, mole_led, swith, hammer_pulse,
    input  hit_vec, miss_pulse, miss_count, primed_vec, lockout_busy
  );

  modport slave (
    input  enable, clear_miss, mole_led, swith, hammer_pulse,
    output hit_vec, miss_pulse, miss_count, primed_vec, lockout_busy
  );
endinterface

// File: rtl/hammer_hit_detector.sv
// Per-lane hit qualifier: synchronises lane switches, tracks each lit mole through
// IDLE/ARMED/PRIMED/SPENT and turns accepted hammer strikes into hit or miss pulses.
module hammer_hit_detector #(
  parameter int LANES          = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCKOUT_CYCLES = 1_000_000,
  parameter int MISS_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hammer_hit_detector_if.slave bus
);

  localparam int                CNT_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ARMED, PRIMED, SPENT} lane_state_e;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v == MISS_MAX) ? v : v + MISS_W'(1);
  endfunction

  logic [LANES-1:0]  sync_q [SYNC_STAGES];
  logic [LANES-1:0]  sw_s;
  logic [LANES-1:0]  sw_prev_q;
  logic [LANES-1:0]  sw_edge_q;
  logic [LANES-1:0]  led_prev_q;
  logic [LANES-1:0]  led_rise;

  lane_state_e       state_q [LANES];
  lane_state_e       state_d [LANES];

  logic [LANES-1:0]  hit_d, hit_q;
  logic              miss_d, miss_q;
  logic [MISS_W-1:0] miss_cnt_d, miss_cnt_q;
  logic [CNT_W-1:0]  lock_d, lock_q;
  logic [LANES-1:0]  primed;
  logic              strike;

  assign sw_s     = sync_q[SYNC_STAGES-1];
  assign led_rise = bus.mole_led & ~led_prev_q;
  assign strike   = bus.hammer_pulse & bus.enable & (lock_q == '0);

  // Input stage: switch synchronisers, registered both-edge detect, LED history
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sw_prev_q  <= '0;
      sw_edge_q  <= '0;
      led_prev_q <= '0;
    end else begin
      sync_q[0] <= bus.swith;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sw_prev_q  <= sw_s;
      sw_edge_q  <= sw_s ^ sw_prev_q;
      led_prev_q <= bus.mole_led;
    end
  end

  // Lane FSMs: disable and a dark LED override everything, including a coincident strike
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      if (!bus.enable || !bus.mole_led[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE:    if (led_rise[i]) state_d[i] = ARMED;
          ARMED:   if (sw_edge_q[i] && !led_rise[i]) state_d[i] = PRIMED;
          PRIMED:  if (strike && sw_s[i]) begin
                     state_d[i] = SPENT;
                     hit_d[i]   = 1'b1;
                   end
          SPENT:   state_d[i] = SPENT;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    miss_d = strike & ~(|hit_d);

    miss_cnt_d = miss_cnt_q;
    if (bus.clear_miss)          miss_cnt_d = '0;
    else if (bus.enable && miss_q) miss_cnt_d = sat_inc(miss_cnt_q);

    lock_d = lock_q;
    if (!bus.enable)        lock_d = '0;
    else if (strike)        lock_d = LOCK_LOAD;
    else if (lock_q != '0)  lock_d = lock_q - CNT_W'(1);

    for (int i = 0; i < LANES; i++) primed[i] = (state_q[i] == PRIMED);
  end

  // Output stage: registered hit/miss pulses, miss counter, lockout timer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
      hit_q      <= '0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
      lock_q     <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.hit_vec      = hit_q;
  assign bus.miss_pulse   = miss_q;
  assign bus.miss_count   = miss_cnt_q;
  assign bus.primed_vec   = primed;
  assign bus.lockout_busy = (lock_q != '0);

endmodule

// File: tb/tb_hammer_hit_detector.sv
// Bench for hammer_hit_detector: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a delay-line reference model.
`timescale 1ns/1ps
module tb_hammer_hit_detector;
  localparam int LANES  = 5;
  localparam int SYNC   = 2;
  localparam int LOCK   = 20;
  localparam int MISS_W = 8;
  localparam int HLEN   = SYNC + 2;

  logic clk = 1'b0;
  logic reset;

  hammer_hit_detector_if #(.LANES(LANES), .MISS_W(MISS_W)) bus ();

  hammer_hit_detector #(
    .LANES(LANES), .SYNC_STAGES(SYNC), .LOCKOUT_CYCLES(LOCK), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hist[k] is the switch vector sampled k+1 edges ago
  logic [LANES-1:0] hist [HLEN];
  logic [LANES-1:0] m_led_prev;
  int               m_stat [LANES];
  int               m_lock;
  int               m_cnt;
  logic [LANES-1:0] e_hit;
  logic [LANES-1:0] e_primed;
  logic             e_miss;
  bit               started = 1'b0;

  always @(posedge clk) begin : model
    logic [LANES-1:0] s_now, edge_now, rise, hits;
    bit strike;
    if (reset) begin
      for (int k = 0; k < HLEN; k++) hist[k] = '0;
      for (int i = 0; i < LANES; i++) m_stat[i] = 0;
      m_led_prev = '0;
      m_lock = 0;
      m_cnt  = 0;
      e_hit  = '0;
      e_miss = 1'b0;
    end else begin
      s_now    = hist[SYNC-1];
      edge_now = hist[SYNC] ^ hist[SYNC+1];
      rise     = bus.mole_led & ~m_led_prev;
      strike   = bus.hammer_pulse && bus.enable && (m_lock == 0);
      hits     = '0;
      for (int i = 0; i < LANES; i++) begin
        if (!bus.enable || !bus.mole_led[i]) m_stat[i] = 0;
        else if (m_stat[i] == 0 && rise[i]) m_stat[i] = 1;
        else if (m_stat[i] == 1 && edge_now[i] && !rise[i]) m_stat[i] = 2;
        else if (m_stat[i] == 2 && strike && s_now[i]) begin
          m_stat[i] = 3;
          hits[i]   = 1'b1;
        end
      end
      if (bus.clear_miss) m_cnt = 0;
      else if (bus.enable && e_miss && m_cnt < (2**MISS_W - 1)) m_cnt++;
      if (!bus.enable) m_lock = 0;
      else if (strike) m_lock = LOCK - 1;
      else if (m_lock > 0) m_lock--;
      for (int k = HLEN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0]    = bus.swith;
      m_led_prev = bus.mole_led;
      e_hit      = hits;
      e_miss     = strike && (hits == '0);
    end
    for (int i = 0; i < LANES; i++) e_primed[i] = (m_stat[i] == 2);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("hit_vec",      bus.hit_vec,      e_hit);
      check("miss_pulse",   bus.miss_pulse,   e_miss);
      check("miss_count",   bus.miss_count,   m_cnt);
      check("primed_vec",   bus.primed_vec,   e_primed);
      check("lockout_busy", bus.lockout_busy, m_lock != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strike1();
    bus.hammer_pulse = 1'b1;
    tick(1);
    bus.hammer_pulse = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.clear_miss   = 1'b0;
    bus.mole_led     = '0;
    bus.swith        = 5'b00100;
    bus.hammer_pulse = 1'b0;
    tick(10);
    reset = 1'b0;
    tick(6);
    check("rst_primed", bus.primed_vec, 5'b00000);
    check("rst_hit",    bus.hit_vec,    5'b00000);
    check("rst_count",  bus.miss_count, 0);
    check("rst_busy",   bus.lockout_busy, 1'b0);

    // Lane 1 lit, switch toggled, strike -> single hit
    bus.mole_led = 5'b00010;
    tick(1);
    bus.swith[1] = 1'b1;
    tick(4);
    check("l1_primed", bus.primed_vec, 5'b00010);
    strike1();
    check("l1_hit",  bus.hit_vec,    5'b00010);
    check("l1_miss", bus.miss_pulse, 1'b0);
    tick(1);
    check("l1_hit_off", bus.hit_vec,    5'b00000);
    check("l1_count",   bus.miss_count, 0);

    // Strike before the switch toggles -> miss; second strike inside lockout ignored
    bus.mole_led = '0;
    tick(LOCK + 2);
    bus.mole_led = 5'b00010;
    tick(2);
    strike1();
    check("early_miss", bus.miss_pulse, 1'b1);
    check("early_hit",  bus.hit_vec,    5'b00000);
    tick(1);
    check("early_count", bus.miss_count, 1);
    tick(3);
    strike1();
    check("lock_miss", bus.miss_pulse, 1'b0);
    tick(1);
    check("lock_count", bus.miss_count, 1);
    check("lock_busy",  bus.lockout_busy, 1'b1);

    // Primed with switch low: strike does not score and the lane stays primed
    tick(LOCK);
    bus.swith[1] = 1'b0;
    tick(4);
    strike1();
    check("sw0_hit",    bus.hit_vec,    5'b00000);
    check("sw0_primed", bus.primed_vec, 5'b00010);
    bus.swith[1] = 1'b1;
    tick(LOCK);
    strike1();
    check("l1_hit2", bus.hit_vec, 5'b00010);

    // Spent lane does not re-arm while its LED stays lit
    bus.swith[1] = 1'b0;
    tick(LOCK + 2);
    check("spent_primed", bus.primed_vec, 5'b00000);
    strike1();
    check("spent_hit",  bus.hit_vec,    5'b00000);
    check("spent_miss", bus.miss_pulse, 1'b1);
    tick(1);
    check("spent_count", bus.miss_count, 3);

    // Two lanes on one strike, then a strike coincident with lane 4 going dark
    bus.mole_led = '0;
    tick(LOCK);
    bus.mole_led = 5'b10001;
    tick(1);
    bus.swith[0] = 1'b1;
    bus.swith[4] = 1'b1;
    tick(4);
    check("dual_primed", bus.primed_vec, 5'b10001);
    strike1();
    check("dual_hit", bus.hit_vec, 5'b10001);
    tick(LOCK);
    bus.mole_led = '0;
    tick(1);
    bus.mole_led = 5'b10001;
    tick(1);
    bus.swith[0] = 1'b0;
    bus.swith[4] = 1'b0;
    tick(4);
    bus.swith[0] = 1'b1;
    bus.swith[4] = 1'b1;
    tick(4);
    check("fall_primed", bus.primed_vec, 5'b10001);
    bus.mole_led     = 5'b00001;
    bus.hammer_pulse = 1'b1;
    tick(1);
    bus.hammer_pulse = 1'b0;
    check("fall_hit", bus.hit_vec, 5'b00001);

    // Saturate the miss counter, then clear it in the same cycle as a miss
    bus.mole_led = '0;
    tick(LOCK);
    for (int n = 0; n < 260; n++) begin
      strike1();
      tick(LOCK);
    end
    check("sat_count", bus.miss_count, 255);
    strike1();
    check("clr_miss", bus.miss_pulse, 1'b1);
    bus.clear_miss = 1'b1;
    tick(1);
    bus.clear_miss = 1'b0;
    check("clr_count", bus.miss_count, 0);

    // Randomized traffic, including disable, clears and mid-run resets
    tick(LOCK);
    for (int c = 0; c < 3000; c++) begin
      bus.hammer_pulse = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) bus.mole_led[$urandom_range(0, LANES-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0)  bus.swith[$urandom_range(0, LANES-1)] ^= 1'b1;
      bus.enable     = ($urandom_range(0, 99) != 0);
      bus.clear_miss = ($urandom_range(0, 199) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset            = 1'b0;
    bus.enable       = 1'b1;
    bus.clear_miss   = 1'b0;
    bus.hammer_pulse = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hammer_hit_detector.md
Name: hammer_hit_detector

Overview:
Per-lane hit qualifier that sits directly upstream of the mole LED/random controller, and replaces the ad-hoc switch-edge logic in the top level. It synchronises the raw lane switches and tracks each lit mole through a small per-lane FSM. When a debounced hammer pulse arrives, it issues a one-cycle hit vector. Accepted hammer strikes that hit nothing are reported as misses and counted. A post-strike lockout window rejects repeated strikes.

Parameters:
LANES, 5, number of mole lanes (LED/switch pairs)
SYNC_STAGES, 2, flip-flop stages in each switch synchroniser (min 2)
LOCKOUT_CYCLES, 1_000_000, clk cycles after an accepted hammer pulse during which further hammer pulses are ignored (min 1)
MISS_W, 8, width of the saturating miss counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  detector active; low forces all lanes to IDLE
clear_miss  in  1  synchronous clear of miss_count
mole_led  in  LANES  lit-mole vector from the mole controller
swith  in  LANES  raw lane switches (asynchronous)
hammer_pulse  in  1  one-cycle debounced hammer strike
hit_vec  out  LANES  registered one-cycle hit pulse per lane, to the mole controller
miss_pulse  out  1  registered one-cycle pulse on an accepted strike with no lane hit
miss_count  out  MISS_W  saturating count of misses
primed_vec  out  LANES  status: lane is in PRIMED
lockout_busy  out  1  lockout window active

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: hit_vec=0, miss_pulse=0, miss_count=0, primed_vec=0, lockout_busy=0. All synchroniser flops, the previous-switch register and the previous-LED register are 0. Lockout counter is 0. All lanes are IDLE.
- Synchroniser and edge detect:
  - Each swith bit passes through SYNC_STAGES flops to give sw_s.
  - sw_edge = sw_s XOR sw_s_prev, registered, so it covers 0->1 and 1->0.
  - Latency from a swith change to sw_edge is SYNC_STAGES+1 cycles.
- LED rise: led_rise = mole_led & ~mole_led_prev.
- Strike acceptance: strike = hammer_pulse & enable & (lockout counter == 0).
- Per-lane FSM, states IDLE, ARMED, PRIMED, SPENT:
  - IDLE -> ARMED on led_rise.
  - ARMED -> PRIMED on sw_edge while mole_led is high. An edge in the same cycle as led_rise is ignored.
  - PRIMED -> SPENT on strike when sw_s=1. This sets the lane's hit_vec bit in the next cycle.
  - PRIMED stays in PRIMED on strike when sw_s=0. No hit is issued for that lane.
  - ARMED stays in ARMED on strike. No hit is issued.
  - SPENT -> IDLE when mole_led falls. SPENT never re-arms while the LED stays high, which prevents a double score.
  - Any non-IDLE state -> IDLE when mole_led is low.
  - Any state -> IDLE when enable=0.
  - Edges seen while a lane is IDLE or SPENT are discarded.
- hit_vec: registered, one cycle high, asserted 1 cycle after the strike cycle. Several bits may be set for the same strike.
- miss_pulse: asserted 1 cycle after a strike where no lane qualifies.
- miss_count: increments by 1 on each miss_pulse cycle and saturates at 2^MISS_W-1.
  - clear_miss zeroes it and takes priority over a simultaneous increment.
  - Held while enable=0.
- Lockout:
  - On strike the counter loads LOCKOUT_CYCLES-1 if LOCKOUT_CYCLES>1, else stays 0. It then decrements to 0.
  - lockout_busy = (counter != 0).
  - hammer_pulse during lockout is ignored completely: no hit, no miss, no state change.
  - enable=0 clears the counter.
- Simultaneous strike and LED fall in PRIMED: the lane goes to IDLE and no hit is issued, because the LED fall has priority.
- Switches held high through reset: synchroniser output rises SYNC_STAGES cycles after reset release. That rise is a real edge and is honoured only if the lane is ARMED.
- Reset mid-operation: all state and outputs return to reset values on the next edge, regardless of pending hits.

Test Plan:
- Reset with swith=5'b00100 and mole_led=0 for 10 cycles, then release -> all outputs 0; lane2 stays IDLE after the synchroniser edge.
- mole_led=5'b00010, toggle swith[1] 0->1, wait 4 cycles, pulse hammer_pulse -> hit_vec=5'b00010 for exactly 1 cycle, 1 cycle after the pulse; miss_count stays 0.
- Same setup but hammer pulse before the switch toggle -> hit_vec=0, miss_pulse=1, miss_count=1. A second pulse inside LOCKOUT_CYCLES (set to 20) -> nothing.
- Lane1 hit, LED held high, toggle swith[1] again and strike after lockout -> no hit, since the lane is SPENT; miss_count increments.
- Lanes 0 and 4 both PRIMED with sw_s=1, one strike -> hit_vec=5'b10001. In the same test, strike coincident with mole_led[4] falling -> only bit0 set.
- Force 255 misses with MISS_W=8, then one more -> miss_count=255 (saturated). clear_miss together with a miss -> miss_count=0.
